// File: rtl/line_mem_responder_pkg.sv
// Shared constants and state encoding for the 128-bit line memory request interface.
// Cache-side benches import this package too.
package mem_if_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;
  localparam int OFF_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/line_mem_responder_if.sv
// Line request bus between the data cache miss/write-back path and main memory.
interface line_mem_if;
  import mem_if_pkg::*;

  // Handshake: master raises mem_req_valid with addr/wr/data and holds them stable
  // until it sees mem_req_ready, a one-cycle completion pulse; read data is valid
  // in that ready cycle and is held until the next read completes.
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_valid;
  logic              mem_req_wr;
  logic [LINE_W-1:0] mem_wr_data;
  logic [LINE_W-1:0] mem_rd_data;
  logic              mem_req_ready;

  modport master (
    output mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
    input  mem_rd_data, mem_req_ready
  );

  modport slave (
    input  mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
    output mem_rd_data, mem_req_ready
  );
endinterface

// File: rtl/line_mem_responder_line_ram.sv
// Single-port synchronous line RAM with registered read data.
// Read data holds its value until the next read access.
module line_ram
  import mem_if_pkg::*;
#(
  parameter int LINE_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               we,
  input  logic [LINE_AW-1:0] addr,
  input  logic [LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata
);
  logic [LINE_W-1:0] mem [2**LINE_AW];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/line_mem_responder.sv
// Main-memory responder: one line read/write at a time, completed after LATENCY
// cycles with a one-cycle ready pulse.
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LINE_AW = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  line_mem_if.slave   bus,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output state_t      dbg_state
);
  localparam bit          LAT_ONE  = (LATENCY == 1);
  localparam logic [7:0]  CNT_INIT = LAT_ONE ? 8'd0 : 8'(LATENCY - 2);

  state_t              state, state_nx;
  logic [7:0]          cnt;
  logic [LINE_AW-1:0]  idx_q;
  logic                wr_q;
  logic [LINE_W-1:0]   data_q;
  logic                acc_en, acc_we, live;
  logic [LINE_AW-1:0]  acc_idx;
  logic [LINE_W-1:0]   acc_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.mem_req_valid) state_nx = LAT_ONE ? RESP : WAIT;
      WAIT:    if (cnt == 8'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY==1 the access happens at the accepting edge, so it must use
  // the live bus fields instead of the (not yet loaded) latches.
  always_comb begin
    bus.mem_req_ready = (state == RESP);
    dbg_state         = state;
    live              = (state == IDLE);
    acc_en            = (live && bus.mem_req_valid && LAT_ONE) ||
                        ((state == WAIT) && (cnt == 8'd0));
    acc_we            = live ? bus.mem_req_wr : wr_q;
    acc_idx           = live ? bus.mem_req_addr[LINE_AW+OFF_W-1:OFF_W] : idx_q;
    acc_data          = live ? bus.mem_wr_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == IDLE && bus.mem_req_valid) begin
        idx_q  <= bus.mem_req_addr[LINE_AW+OFF_W-1:OFF_W];
        wr_q   <= bus.mem_req_wr;
        data_q <= bus.mem_wr_data;
        cnt    <= CNT_INIT;
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (acc_en) begin
        if (acc_we) wr_count <= wr_count + 32'd1;
        else        rd_count <= rd_count + 32'd1;
      end
    end
  end

  line_ram #(.LINE_AW(LINE_AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (acc_en),
    .we    (acc_we),
    .addr  (acc_idx),
    .wdata (acc_data),
    .rdata (bus.mem_rd_data)
  );
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_line_mem_responder;
  import mem_if_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_mem_if bus4 ();
  line_mem_if bus1 ();
  logic [31:0] rd_count4, wr_count4, rd_count1, wr_count1;
  state_t      dbg_state4, dbg_state1;

  line_mem_responder #(.LINE_AW(10), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .rd_count(rd_count4), .wr_count(wr_count4), .dbg_state(dbg_state4)
  );

  line_mem_responder #(.LINE_AW(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .rd_count(rd_count1), .wr_count(wr_count1), .dbg_state(dbg_state1)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] V_L4  = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] V_BEE = 128'hDEADBEEF_CAFEF00D_11223344_55667788;
  localparam logic [127:0] V_L5  = 128'h5555_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] V_L6  = 128'h6666_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam logic [127:0] V_OLD = 128'h0707_0707_0707_0707_0707_0707_0707_0707;
  localparam logic [127:0] V_NEW = 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0;
  localparam logic [127:0] V_ALI = 128'hA11A_5000_0000_0001_A11A_5000_0000_0001;
  localparam logic [127:0] V_W1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=4 bus; returns at the negedge of the ready cycle.
  task automatic req4(input logic [31:0] a, input logic w, input logic [127:0] d,
                      input bit drop, output int lat);
    @(negedge clk);
    bus4.mem_req_addr  = a;
    bus4.mem_req_wr    = w;
    bus4.mem_wr_data   = d;
    bus4.mem_req_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (drop && k == 1) begin
        bus4.mem_req_valid = 1'b0;
        bus4.mem_req_addr  = 32'h0000_0060;
        bus4.mem_req_wr    = ~w;
        bus4.mem_wr_data   = '0;
      end
      if (bus4.mem_req_ready) begin
        lat = k;
        break;
      end
    end
    bus4.mem_req_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int pulses;
    bus4.mem_req_addr = '0; bus4.mem_req_valid = 1'b0; bus4.mem_req_wr = 1'b0; bus4.mem_wr_data = '0;
    bus1.mem_req_addr = '0; bus1.mem_req_valid = 1'b0; bus1.mem_req_wr = 1'b0; bus1.mem_wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready",  128'(bus4.mem_req_ready), 128'd0);
    check("rst_rddata", bus4.mem_rd_data, 128'd0);
    check("rst_rdcnt",  128'(rd_count4), 128'd0);
    check("rst_wrcnt",  128'(wr_count4), 128'd0);
    check("rst_state",  128'(dbg_state4), 128'(IDLE));

    // Preload line 4 then read it back at latency 4
    req4(32'h0000_0040, 1'b1, V_L4, 1'b0, lat);
    check("wr_l4_lat", 128'(lat), 128'd4);
    @(negedge clk);
    check("ready_one_cycle", 128'(bus4.mem_req_ready), 128'd0);
    req4(32'h0000_0040, 1'b0, '0, 1'b0, lat);
    check("rd_l4_lat",  128'(lat), 128'd4);
    check("rd_l4_data", bus4.mem_rd_data, V_L4);
    check("rd_l4_cnt",  128'(rd_count4), 128'd1);

    // Write then read with a different in-line offset
    req4(32'h0000_0100, 1'b1, V_BEE, 1'b0, lat);
    check("wr_bee_lat",   128'(lat), 128'd4);
    check("wr_rd_hold",   bus4.mem_rd_data, V_L4);
    req4(32'h0000_010C, 1'b0, '0, 1'b0, lat);
    check("rd_bee_data",  bus4.mem_rd_data, V_BEE);
    check("cnt_after_bee_wr", 128'(wr_count4), 128'd2);
    check("cnt_after_bee_rd", 128'(rd_count4), 128'd2);

    // Request fields changing after acceptance have no effect
    req4(32'h0000_0050, 1'b1, V_L5, 1'b0, lat);
    req4(32'h0000_0060, 1'b1, V_L6, 1'b0, lat);
    req4(32'h0000_0050, 1'b0, '0, 1'b1, lat);
    check("drop_lat",  128'(lat), 128'd4);
    check("drop_data", bus4.mem_rd_data, V_L5);
    check("drop_rdcnt", 128'(rd_count4), 128'd3);
    check("drop_wrcnt", 128'(wr_count4), 128'd4);

    // Reset during WAIT of a write to line 7
    req4(32'h0000_0070, 1'b1, V_OLD, 1'b0, lat);
    @(negedge clk);
    bus4.mem_req_addr  = 32'h0000_0070;
    bus4.mem_req_wr    = 1'b1;
    bus4.mem_wr_data   = V_NEW;
    bus4.mem_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_state", 128'(dbg_state4), 128'(WAIT));
    rst = 1'b1;
    bus4.mem_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid_ready", 128'(bus4.mem_req_ready), 128'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_ready", 128'(bus4.mem_req_ready), 128'd0);
    end
    check("post_rst_rdcnt", 128'(rd_count4), 128'd0);
    check("post_rst_wrcnt", 128'(wr_count4), 128'd0);
    check("post_rst_state", 128'(dbg_state4), 128'(IDLE));
    req4(32'h0000_0070, 1'b0, '0, 1'b0, lat);
    check("l7_old_data", bus4.mem_rd_data, V_OLD);
    check("l7_rdcnt",    128'(rd_count4), 128'd1);

    // Address aliasing: 0x0001_4010 and 0x0000_0010 are both line 1
    req4(32'h0001_4010, 1'b1, V_ALI, 1'b0, lat);
    req4(32'h0000_0010, 1'b0, '0, 1'b0, lat);
    check("alias_data",  bus4.mem_rd_data, V_ALI);
    check("alias_wrcnt", 128'(wr_count4), 128'd1);
    check("alias_rdcnt", 128'(rd_count4), 128'd2);

    // LATENCY=1: single write completes one cycle after acceptance
    @(negedge clk);
    bus1.mem_req_addr  = 32'h0000_0020;
    bus1.mem_req_wr    = 1'b1;
    bus1.mem_wr_data   = V_W1;
    bus1.mem_req_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus1.mem_req_ready) begin
        lat = k;
        break;
      end
    end
    bus1.mem_req_valid = 1'b0;
    check("l1_wr_lat",   128'(lat), 128'd1);
    check("l1_wr_cnt",   128'(wr_count1), 128'd1);

    // LATENCY=1: valid held high, ready every second cycle
    @(negedge clk);
    bus1.mem_req_wr    = 1'b0;
    bus1.mem_req_valid = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("l1_b2b_ready", 128'(bus1.mem_req_ready), 128'(k % 2));
      if (bus1.mem_req_ready) pulses++;
      if (k == 1) check("l1_rd_data", bus1.mem_rd_data, V_W1);
    end
    bus1.mem_req_valid = 1'b0;
    @(negedge clk);
    check("l1_pulses", 128'(pulses), 128'd6);
    check("l1_rdcnt",  128'(rd_count1), 128'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the 128-bit cache-line request interface driven by the data cache's miss/write-back path.
- Accepts one line read or line write at a time, serves it from an internal line-wide RAM after a fixed, parameterised latency, and signals completion with a one-cycle ready pulse.
- Serves as the main-memory model for cache integration and sits directly behind the cache's mem_req_* port.

Parameters:
- LINE_AW, 10, log2 of number of 128-bit lines held (1024 lines = 16 KiB).
- LATENCY, 4, cycles from request acceptance to ready pulse; legal range 1..255.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- mem_req_addr  input  32  byte address of line; bits [3:0] ignored.
- mem_req_valid  input  1  request present; requester holds addr/wr/data stable until ready.
- mem_req_wr  input  1  1 = line write, 0 = line read.
- mem_wr_data  input  128  write line data.
- mem_rd_data  output  128  read line data, valid in the ready cycle, held until next read completion.
- mem_req_ready  output  1  one-cycle completion pulse.
- rd_count  output  32  completed reads, wraps.
- wr_count  output  32  completed writes, wraps.

Behaviour:
- Reset values: mem_req_ready=0, mem_rd_data=0, rd_count=0, wr_count=0, state=IDLE, latency counter=0. RAM contents are not reset.
- Line index = mem_req_addr[LINE_AW+3:4]. Higher address bits are ignored, so addresses alias modulo 2^LINE_AW lines.
- State machine:
  - IDLE: on a clock edge with mem_req_valid=1, latch addr, wr and wr_data.
    - If LATENCY==1, go to RESP and perform the access at that same edge, using the live inputs.
    - Otherwise go to WAIT with counter=LATENCY-2.
  - WAIT: decrement the counter each cycle. At the edge where the counter is 0, perform the RAM access from the latched fields and go to RESP.
  - RESP: mem_req_ready=1 for exactly this cycle; go to IDLE unconditionally.
- Latency: valid sampled at edge t gives ready high in the cycle following edge t+LATENCY-1, i.e. LATENCY cycles after acceptance.
- RAM access at the edge entering RESP:
  - Read: mem_rd_data <= ram[idx]; rd_count++.
  - Write: ram[idx] <= wr_data; wr_count++; mem_rd_data unchanged.
- IDLE always lasts at least one cycle after RESP (minimum 1-cycle turnaround). Back-to-back throughput is therefore one request per LATENCY+1 cycles.
- If valid is still high in the IDLE cycle after RESP, it is treated as a new request.
- Valid or request fields changing after acceptance have no effect; the latched request completes.
- mem_req_ready is never asserted outside RESP, and never for more than one consecutive cycle.
- Read after write to the same line returns the written data, since the write is committed before the next acceptance.
- Reset mid-operation (WAIT or RESP) aborts to IDLE with ready=0. If the reset occurs before the access edge, no RAM write occurs and the counters are cleared.
- Counters wrap 0xFFFFFFFF -> 0.

Decomposition:
- Shared package mem_if_pkg holds:
  - LINE_W=128 and ADDR_W=32 constants.
  - Line offset width OFF_W=4.
  - State encoding IDLE/WAIT/RESP as a localparam enum, also usable by cache-side benches.
- One natural sub-module: line_ram.
  - Single-port synchronous RAM, 2^LINE_AW x 128.
  - Write-enable, registered read-data port.
  - The responder FSM drives its enable and write-enable.

Test Plan:
- Reset then read addr 0x0000_0040 with RAM preloaded line 4 = 0x0123..CDEF: ready pulses exactly 4 cycles after acceptance, mem_rd_data = preload, rd_count=1.
- Write 0xDEADBEEF_CAFEF00D_11223344_55667788 to 0x0000_0100, then read 0x0000_010C: read returns the same 128-bit value; wr_count=1, rd_count=1; mem_rd_data does not change during the write's ready cycle.
- LATENCY=1 build, back-to-back reads with valid held continuously: ready pulses every 2nd cycle, never in consecutive cycles.
- Drop valid and change addr one cycle after acceptance: the original request still completes with the original line data at the original latency.
- Assert rst in WAIT of a write to line 7: ready never pulses, line 7 keeps its old value, counters read 0 after reset.
- LINE_AW=10, write to 0x0001_4010 then read 0x0000_0010: aliasing returns the written data (both map to line 1).
